// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with an 8-deep byte FIFO.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   bus_addr  CPU address; registers live at BASE..BASE+4
//   bus_we    write strobe for bus_addr
//   bus_wdata write data
//   bus_rdata registered read data, one cycle after bus_addr
//   tx        serial line, idle high, LSB first
//   tx_int    one-cycle pulse when FIFO and shifter have drained
module mmio_uart_tx #(
  parameter int BASE        = 980,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_addr,
  input  logic        bus_we,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        tx,
  output logic        tx_int
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, ctrl_en, ctrl_ie, cond_prev;
  logic [15:0]   div, baud_cnt, off, eff_div;
  logic [7:0]    shift, status, rd_mux;
  logic [2:0]    bit_cnt;
  logic [3:0]    cnt_disp;
  logic          wr_data, wr_ctrl, wr_lo, wr_hi, full, empty, pop, push, bit_end, cond;
  assign off      = bus_addr - 16'(BASE);
  assign wr_data  = bus_we && off == 16'd0;
  assign wr_ctrl  = bus_we && off == 16'd2;
  assign wr_lo    = bus_we && off == 16'd3;
  assign wr_hi    = bus_we && off == 16'd4;
  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign eff_div  = div == 16'd0 ? 16'd1 : div;
  assign bit_end  = baud_cnt == 16'd0;
  assign pop      = state == IDLE && ctrl_en && !empty;
  // a pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push     = wr_data && (!full || pop);
  assign cond     = state == IDLE && empty;
  // cond_prev resets high so reset release never looks like a drain event
  assign tx_int   = ctrl_ie && cond && !cond_prev;
  assign cnt_disp = (32'(count) > 32'd15) ? 4'hF : 4'(count);
  assign status   = {cnt_disp, overflow, empty, full, state != IDLE};
  assign rd_mux   = off == 16'd1 ? status :
                    off == 16'd2 ? {6'b0, ctrl_ie, ctrl_en} :
                    off == 16'd3 ? div[7:0] :
                    off == 16'd4 ? div[15:8] : 8'h00;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pop) state_n = START;
      START:   if (bit_end) state_n = DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) state_n = STOP;
      STOP:    if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus_wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      ctrl_en   <= 1'b1;
      ctrl_ie   <= 1'b0;
      div       <= 16'(DEFAULT_DIV);
      baud_cnt  <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      cond_prev <= 1'b1;
      bus_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // the divisor is re-sampled at every bit boundary reload
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        shift    <= mem[rd_ptr];
        bit_cnt  <= '0;
        baud_cnt <= eff_div - 16'd1;
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? eff_div - 16'd1 : baud_cnt - 16'd1;
      end
      if (state == DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (wr_data && !push) overflow <= 1'b1;
      else if (wr_ctrl && bus_wdata[2]) overflow <= 1'b0;
      if (wr_ctrl) begin
        ctrl_en <= bus_wdata[0];
        ctrl_ie <= bus_wdata[1];
      end
      if (wr_lo) div[7:0] <= bus_wdata;
      if (wr_hi) div[15:8] <= bus_wdata;
      // tx is registered from the state, so the line trails the FSM by one clock
      tx        <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      cond_prev <= cond;
      bus_rdata <= rd_mux;
    end
  end
endmodule
